// File: rtl/counter_arb_pkg.sv
// Shared types and default widths for the counter access arbiter.
package counter_arb_pkg;

   localparam int unsigned N_REQ_DEF  = 4;
   localparam int unsigned CNT_W_DEF  = 4;
   localparam int unsigned STEP_W_DEF = 4;
   localparam int unsigned CNT_MAX    = (1 << CNT_W_DEF) - 1;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } arb_state_e;

   // Round-robin successor of a requester index.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/counter_access_arbiter_if.sv
// Request/grant, counter-drive and completion signals of the counter access arbiter.
interface counter_access_arbiter_if #(
   parameter int unsigned N_REQ  = counter_arb_pkg::N_REQ_DEF,
   parameter int unsigned CNT_W  = counter_arb_pkg::CNT_W_DEF,
   parameter int unsigned STEP_W = counter_arb_pkg::STEP_W_DEF,
   localparam int unsigned IdW   = $clog2(N_REQ)
);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_up;
   logic [N_REQ*STEP_W-1:0] req_steps;
   logic [N_REQ-1:0]        req_ready;
   logic [CNT_W-1:0]        count;
   logic                    increment;
   logic                    decrement;
   logic                    busy;
   logic                    done_valid;
   logic [IdW-1:0]          done_id;
   logic [STEP_W-1:0]       done_issued;
   logic                    done_clipped;

   // Requesters plus the counter instance.
   modport master (
      output req_valid, req_up, req_steps, count,
      input  req_ready, increment, decrement, busy, done_valid, done_id, done_issued,
             done_clipped
   );

   // The arbiter.
   modport slave (
      input  req_valid, req_up, req_steps, count,
      output req_ready, increment, decrement, busy, done_valid, done_id, done_issued,
             done_clipped
   );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit at or after ptr, wrapping.
module rr_pick #(
   parameter int unsigned N     = 4,
   localparam int unsigned IdxW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [IdxW-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [IdxW-1:0] idx,
   output logic            any
);

   // Scan N positions starting at ptr; the first hit wins.
   always_comb begin
      int unsigned j;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = (32'(ptr) + k) % N;
         if (!any && req[j]) begin
            any      = 1'b1;
            idx      = IdxW'(j);
            grant[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/counter_access_arbiter.sv
// Round-robin arbiter that steps a shared up/down counter on behalf of N requesters.
module counter_access_arbiter #(
   parameter int unsigned N_REQ    = counter_arb_pkg::N_REQ_DEF,
   parameter int unsigned CNT_W    = counter_arb_pkg::CNT_W_DEF,
   parameter int unsigned STEP_W   = counter_arb_pkg::STEP_W_DEF,
   parameter bit          SATURATE = 1'b1
) (
   input logic                     clk,
   input logic                     reset,
   counter_access_arbiter_if.slave bus
);
   import counter_arb_pkg::*;

   localparam int unsigned IdW = $clog2(N_REQ);
   localparam logic [CNT_W-1:0] CntMax = '1;

   arb_state_e        state_q, state_d;
   logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IdW-1:0]    id_q, id_d;
   logic              up_q, up_d;
   logic              clipped_q, clipped_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic [STEP_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0]  shadow_q, shadow_d;

   logic [N_REQ-1:0]  pick_grant;
   logic [IdW-1:0]    pick_idx;
   logic              pick_any;
   logic              sel_up;
   logic [STEP_W-1:0] sel_steps;
   logic              at_limit;
   logic              pulse;

   rr_pick #(
      .N (N_REQ)
   ) u_pick (
      .req   (bus.req_valid),
      .ptr   (rr_ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Mux out the fields of the requester currently picked.
   always_comb begin
      sel_up    = 1'b0;
      sel_steps = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (pick_grant[i]) begin
            sel_up    = bus.req_up[i];
            sel_steps = bus.req_steps[i*STEP_W +: STEP_W];
         end
      end
   end

   // The shadow tracks the counter, so saturation is known before the pulse is driven.
   assign at_limit = SATURATE && (up_q ? (shadow_q == CntMax) : (shadow_q == '0));
   assign pulse    = (state_q == StRun) && !at_limit;

   // Next-state: grant in idle, one step per run cycle, single done cycle.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      id_d      = id_q;
      up_d      = up_q;
      steps_d   = steps_q;
      shadow_d  = shadow_q;
      issued_d  = issued_q;
      clipped_d = clipped_q;
      unique case (state_q)
         StIdle: begin
            if (pick_any) begin
               id_d      = pick_idx;
               up_d      = sel_up;
               steps_d   = sel_steps;
               shadow_d  = bus.count;
               issued_d  = '0;
               clipped_d = 1'b0;
               rr_ptr_d  = IdW'(rr_next(32'(pick_idx), N_REQ));
               state_d   = (sel_steps == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            if (at_limit) begin
               clipped_d = 1'b1;
               state_d   = StDone;
            end else begin
               shadow_d = up_q ? shadow_q + 1'b1 : shadow_q - 1'b1;
               issued_d = issued_q + 1'b1;
               if (issued_q + 1'b1 == steps_q) state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and request registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         rr_ptr_q  <= '0;
         id_q      <= '0;
         up_q      <= 1'b0;
         steps_q   <= '0;
         shadow_q  <= '0;
         issued_q  <= '0;
         clipped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         id_q      <= id_d;
         up_q      <= up_d;
         steps_q   <= steps_d;
         shadow_q  <= shadow_d;
         issued_q  <= issued_d;
         clipped_q <= clipped_d;
      end
   end

   // Outputs; done fields are zero outside the done cycle.
   always_comb begin
      bus.req_ready    = (state_q == StIdle) ? pick_grant : '0;
      bus.increment    = pulse && up_q;
      bus.decrement    = pulse && !up_q;
      bus.busy         = (state_q != StIdle);
      bus.done_valid   = (state_q == StDone);
      bus.done_id      = (state_q == StDone) ? id_q : '0;
      bus.done_issued  = (state_q == StDone) ? issued_q : '0;
      bus.done_clipped = (state_q == StDone) && clipped_q;
   end

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Directed bench: a saturating and a wrapping arbiter, each in front of a modelled counter.
module tb_counter_access_arbiter;
   import counter_arb_pkg::*;

   localparam int unsigned NR = 4;
   localparam int unsigned CW = 4;
   localparam int unsigned SW = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   counter_access_arbiter_if #(.N_REQ(NR), .CNT_W(CW), .STEP_W(SW)) bus_s ();
   counter_access_arbiter_if #(.N_REQ(NR), .CNT_W(CW), .STEP_W(SW)) bus_w ();

   counter_access_arbiter #(
      .N_REQ (NR), .CNT_W (CW), .STEP_W (SW), .SATURATE (1'b1)
   ) u_dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_s)
   );

   counter_access_arbiter #(
      .N_REQ (NR), .CNT_W (CW), .STEP_W (SW), .SATURATE (1'b0)
   ) u_dut_wrap (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_w)
   );

   // Counter models, with a preload port on the saturating side.
   logic          load_en = 1'b0;
   logic [CW-1:0] load_val = '0;
   always @(posedge clk) begin
      if (reset) bus_s.count <= '0;
      else if (load_en) bus_s.count <= load_val;
      else if (bus_s.increment) bus_s.count <= bus_s.count + 1'b1;
      else if (bus_s.decrement) bus_s.count <= bus_s.count - 1'b1;
   end
   always @(posedge clk) begin
      if (reset) bus_w.count <= '0;
      else if (bus_w.increment) bus_w.count <= bus_w.count + 1'b1;
      else if (bus_w.decrement) bus_w.count <= bus_w.count - 1'b1;
   end

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int unsigned cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Which DUT the collector watches: 0 saturating, 1 wrapping.
   logic          sel_w = 1'b0;
   logic          m_inc, m_dec, m_done, m_clip;
   logic [1:0]    m_id;
   logic [SW-1:0] m_issued;
   logic [CW-1:0] m_count;
   assign m_inc    = sel_w ? bus_w.increment    : bus_s.increment;
   assign m_dec    = sel_w ? bus_w.decrement    : bus_s.decrement;
   assign m_done   = sel_w ? bus_w.done_valid   : bus_s.done_valid;
   assign m_clip   = sel_w ? bus_w.done_clipped : bus_s.done_clipped;
   assign m_id     = sel_w ? bus_w.done_id      : bus_s.done_id;
   assign m_issued = sel_w ? bus_w.done_issued  : bus_s.done_issued;
   assign m_count  = sel_w ? bus_w.count        : bus_s.count;

   int unsigned c_inc, c_dec, c_cyc;
   logic        c_done;
   logic [31:0] c_id, c_issued, c_clip, c_count;

   // Called right after the grant edge; counts pulses until the done cycle.
   task automatic collect(input int unsigned budget);
      c_inc = 0; c_dec = 0; c_cyc = 0; c_done = 1'b0;
      c_id = '1; c_issued = '1; c_clip = '1; c_count = '1;
      #1;
      while (!c_done && c_cyc < budget) begin
         c_inc += 32'(m_inc);
         c_dec += 32'(m_dec);
         if (m_done) begin
            c_done   = 1'b1;
            c_id     = 32'(m_id);
            c_issued = 32'(m_issued);
            c_clip   = 32'(m_clip);
            c_count  = 32'(m_count);
         end else begin
            tick();
            #1;
            c_cyc++;
         end
      end
      check_eq("done_seen", 32'(c_done), 1);
   endtask

   // Accept/done tallies for the done-per-accept invariant.
   int unsigned acc_s = 0, done_s = 0, acc_w = 0, done_w = 0;
   always @(posedge clk) begin
      if (!reset) begin
         acc_s  <= acc_s + 32'(|bus_s.req_ready);
         acc_w  <= acc_w + 32'(|bus_w.req_ready);
         done_s <= done_s + 32'(bus_s.done_valid);
         done_w <= done_w + 32'(bus_w.done_valid);
      end
   end

   // Per-cycle invariants on both DUTs.
   always @(negedge clk) begin
      check_eq("s_inc_dec_excl", 32'(bus_s.increment & bus_s.decrement), 0);
      check_eq("s_ready_onehot", 32'($onehot0(bus_s.req_ready)), 1);
      check_eq("s_ready_idle", 32'((|bus_s.req_ready) & bus_s.busy), 0);
      check_eq("s_done_le_acc", 32'(done_s + 32'(bus_s.done_valid) <= acc_s), 1);
      check_eq("w_inc_dec_excl", 32'(bus_w.increment & bus_w.decrement), 0);
      check_eq("w_ready_onehot", 32'($onehot0(bus_w.req_ready)), 1);
      check_eq("w_ready_idle", 32'((|bus_w.req_ready) & bus_w.busy), 0);
      check_eq("w_done_le_acc", 32'(done_w + 32'(bus_w.done_valid) <= acc_w), 1);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required normal finish");
      $fatal(1);
   end

   initial begin
      int unsigned last_done;
      int unsigned n_p;
      bus_s.req_valid = '0; bus_s.req_up = '0; bus_s.req_steps = '0;
      bus_w.req_valid = '0; bus_w.req_up = '0; bus_w.req_steps = '0;
      last_done = 0;
      n_p = 0;

      // Reset state
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      #1;
      check_eq("rst_busy", 32'(bus_s.busy), 0);
      check_eq("rst_inc", 32'(bus_s.increment), 0);
      check_eq("rst_dec", 32'(bus_s.decrement), 0);
      check_eq("rst_done", 32'(bus_s.done_valid), 0);
      check_eq("rst_count", 32'(bus_s.count), 0);

      // 1: requester 0, up 3 from 0
      bus_s.req_valid = 4'b0001; bus_s.req_up = 4'b0001; bus_s.req_steps = 16'h0003;
      #1;
      check_eq("t1_ready", 32'(bus_s.req_ready), 32'h1);
      tick();
      check_eq("t1_ready_pulse", 32'(bus_s.req_ready), 0);
      check_eq("t1_busy", 32'(bus_s.busy), 1);
      bus_s.req_valid = '0;
      collect(20);
      check_eq("t1_inc", c_inc, 3);
      check_eq("t1_dec", c_dec, 0);
      check_eq("t1_run_cycles", c_cyc, 3);
      check_eq("t1_issued", c_issued, 3);
      check_eq("t1_clipped", c_clip, 0);
      check_eq("t1_id", c_id, 0);
      check_eq("t1_count", c_count, 3);
      tick();
      check_eq("t1_idle", 32'(bus_s.busy), 0);

      // 2: all four held, up 1 each; expect 0,1,2,3,0 spaced 3 cycles
      reset = 1'b1; tick(); reset = 1'b0;
      bus_s.req_valid = 4'b1111; bus_s.req_up = 4'b1111; bus_s.req_steps = 16'h1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         check_eq("t2_grant", 32'(bus_s.req_ready), 32'(1 << (k % 4)));
         tick();
         collect(10);
         check_eq("t2_id", c_id, 32'(k % 4));
         check_eq("t2_issued", c_issued, 1);
         if (k > 0) check_eq("t2_spacing", cyc_cnt - last_done, 3);
         last_done = cyc_cnt;
         if (k == 4) bus_s.req_valid = '0;
         tick();
      end
      check_eq("t2_count", 32'(bus_s.count), 5);

      // 3: saturation at MAX, up 5 from 14 (pointer now at 1)
      load_en = 1'b1; load_val = CW'(CNT_MAX - 1);
      tick();
      load_en = 1'b0;
      check_eq("t3_preload", 32'(bus_s.count), 14);
      bus_s.req_valid = 4'b0010; bus_s.req_up = 4'b0010; bus_s.req_steps = 16'h0050;
      #1;
      check_eq("t3_ready", 32'(bus_s.req_ready), 32'h2);
      tick();
      bus_s.req_valid = '0;
      collect(20);
      check_eq("t3_inc", c_inc, 1);
      check_eq("t3_run_cycles", c_cyc, 2);
      check_eq("t3_issued", c_issued, 1);
      check_eq("t3_clipped", c_clip, 1);
      check_eq("t3_id", c_id, 1);
      check_eq("t3_count", c_count, 15);
      tick();

      // 5: zero-step request skips RUN (pointer now at 2)
      bus_s.req_valid = 4'b0100; bus_s.req_up = 4'b0100; bus_s.req_steps = 16'h0000;
      #1;
      check_eq("t5_ready", 32'(bus_s.req_ready), 32'h4);
      tick();
      bus_s.req_valid = '0;
      collect(5);
      check_eq("t5_latency", c_cyc, 0);
      check_eq("t5_pulses", c_inc + c_dec, 0);
      check_eq("t5_issued", c_issued, 0);
      check_eq("t5_clipped", c_clip, 0);
      check_eq("t5_id", c_id, 2);
      tick();

      // 6: reset in the 2nd of 4 down-steps by requester 1 (pointer at 3)
      bus_s.req_valid = 4'b0010; bus_s.req_up = 4'b0000; bus_s.req_steps = 16'h0040;
      #1;
      check_eq("t6_ready", 32'(bus_s.req_ready), 32'h2);
      tick();
      bus_s.req_valid = '0;
      #1;
      check_eq("t6_run1_dec", 32'(bus_s.decrement), 1);
      tick();
      check_eq("t6_run2_dec", 32'(bus_s.decrement), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_p = 0;
      for (int k = 0; k < 4; k++) begin
         n_p += 32'(bus_s.increment) + 32'(bus_s.decrement) + 32'(bus_s.done_valid)
              + 32'(bus_s.busy);
         tick();
      end
      check_eq("t6_quiet_after_reset", n_p, 0);
      bus_s.req_valid = 4'b0110;
      #1;
      check_eq("t6_ptr_reset", 32'(bus_s.req_ready), 32'h2);
      bus_s.req_valid = '0;
      tick();

      // 7: already-saturated start, down 2 from 0 (pointer at 0)
      bus_s.req_valid = 4'b0001; bus_s.req_up = 4'b0000; bus_s.req_steps = 16'h0002;
      #1;
      check_eq("t7_ready", 32'(bus_s.req_ready), 32'h1);
      tick();
      bus_s.req_valid = '0;
      collect(10);
      check_eq("t7_dec", c_dec, 0);
      check_eq("t7_issued", c_issued, 0);
      check_eq("t7_clipped", c_clip, 1);
      check_eq("t7_count", c_count, 0);
      tick();

      // 4: wrapping DUT, down 2 from 0
      sel_w = 1'b1;
      bus_w.req_valid = 4'b0001; bus_w.req_up = 4'b0000; bus_w.req_steps = 16'h0002;
      #1;
      check_eq("t4_ready", 32'(bus_w.req_ready), 32'h1);
      tick();
      bus_w.req_valid = '0;
      collect(20);
      check_eq("t4_dec", c_dec, 2);
      check_eq("t4_inc", c_inc, 0);
      check_eq("t4_issued", c_issued, 2);
      check_eq("t4_clipped", c_clip, 0);
      check_eq("t4_count", c_count, 14);
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
